lvdc_timing_sequencer: RTL and testbench

- Central timing controller for the computer. Runs on the buffered oscillator clock.
- Divides each bit time into clock subphases. Counts bit times within a phase time, and phase times within an instruction cycle.
- Decodes the count into the one-hot strobes that sequence the arithmetic, memory and instruction logic.
- Arbitrates halt requests, and optional single-step requests, so that sequencing stops and restarts only on instruction-cycle boundaries.

---
 rtl/lvdc_timing_sequencer.sv | 97 +++++++++
 tb/tb_lvdc_timing_sequencer.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/lvdc_timing_sequencer.sv
// lvdc_timing_sequencer: subphase/bit-time/phase-time counter with halt arbitration on cycle boundaries.
// Define LVDC_SINGLE_STEP_EN to add single-instruction-cycle stepping from HALTED on a step_req edge.
module lvdc_timing_sequencer #(
    parameter int SUBPHASES      = 4,
    parameter int BITS_PER_PHASE = 14,
    parameter int PHASES         = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 halt_req,
    input  logic                 step_req,
    output logic [SUBPHASES-1:0] sub_strobe,
    output logic [3:0]           bit_time,
    output logic [1:0]           phase_time,
    output logic                 bt_end,
    output logic                 cycle_start,
    output logic                 cycle_end,
    output logic                 running,
    output logic                 halted,
    output logic                 seq_err
);
    localparam int SW = $clog2(SUBPHASES);
    localparam int BW = $clog2(BITS_PER_PHASE + 1);
    localparam int PW = $clog2(PHASES + 1);
    typedef enum logic [1:0] {
        RUN,
        HALT_PEND,
        HALTED
`ifdef LVDC_SINGLE_STEP_EN
        , STEP
`endif
    } state_t;
    state_t state;
    logic [SW-1:0] sub;
    logic [BW-1:0] bt;
    logic [PW-1:0] pt;
    logic counting, sub_last, bt_last, pt_last, bad;
    assign counting    = state != HALTED;
    assign sub_last    = sub == SW'(SUBPHASES - 1);
    assign bt_last     = bt == BW'(BITS_PER_PHASE);
    assign pt_last     = pt == PW'(PHASES);
    assign bad         = bt == '0 || bt > BW'(BITS_PER_PHASE) || pt == '0 || pt > PW'(PHASES);
    assign sub_strobe  = counting ? {{(SUBPHASES-1){1'b0}}, 1'b1} << sub : '0;
    assign bit_time    = 4'(bt);
    assign phase_time  = 2'(pt);
    assign bt_end      = counting & sub_last;
    assign cycle_start = counting & sub == '0 & bt == BW'(1) & pt == PW'(1);
    assign cycle_end   = counting & sub_last & bt_last & pt_last;
    assign running     = counting;
    assign halted      = state == HALTED;
`ifdef LVDC_SINGLE_STEP_EN
    logic step_q, step_edge;
    assign step_edge = step_req & ~step_q;
    always_ff @(posedge clk or posedge rst)
        if (rst) step_q <= 1'b0;
        else step_q <= step_req;
`else
    logic unused_step;
    assign unused_step = step_req;
`endif
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            sub     <= '0;
            bt      <= BW'(1);
            pt      <= PW'(1);
            seq_err <= 1'b0;
        end else begin
            // A corrupted count forces a clean restart at the top of the cycle.
            if (bad) begin
                seq_err <= 1'b1;
                sub     <= '0;
                bt      <= BW'(1);
                pt      <= PW'(1);
            end else if (counting) begin
                sub <= sub_last ? '0 : sub + SW'(1);
                if (sub_last) bt <= bt_last ? BW'(1) : bt + BW'(1);
                if (sub_last && bt_last) pt <= pt_last ? PW'(1) : pt + PW'(1);
            end else begin
                sub <= '0;
                bt  <= BW'(1);
                pt  <= PW'(1);
            end
            case (state)
                RUN:       if (halt_req) state <= cycle_end ? HALTED : HALT_PEND;
                HALT_PEND: state <= !halt_req ? RUN : cycle_end ? HALTED : HALT_PEND;
`ifdef LVDC_SINGLE_STEP_EN
                HALTED:    state <= step_edge ? STEP : !halt_req ? RUN : HALTED;
                STEP:      if (cycle_end) state <= halt_req ? HALTED : RUN;
`else
                HALTED:    if (!halt_req) state <= RUN;
`endif
                default:   state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_lvdc_timing_sequencer.sv
// tb_lvdc_timing_sequencer: directed table and sequence checks for lvdc_timing_sequencer.
module tb_lvdc_timing_sequencer;
    logic clk = 0, rst = 1, halt_req = 0, step_req = 0;
    logic [3:0] sub_strobe, bit_time;
    logic [1:0] phase_time;
    logic bt_end, cycle_start, cycle_end, running, halted, seq_err;
    int pass_n = 0, total_n = 0, off = 0, stalls = 0, bad_n = 0, cnt = 0;
    typedef struct {int n; int sub; int bt; int pt; logic cs; logic ce; logic be;} vec_t;
    vec_t tbl[12];
    always #5 clk = ~clk;
    lvdc_timing_sequencer dut (
        .clk(clk), .rst(rst), .halt_req(halt_req), .step_req(step_req),
        .sub_strobe(sub_strobe), .bit_time(bit_time), .phase_time(phase_time),
        .bt_end(bt_end), .cycle_start(cycle_start), .cycle_end(cycle_end),
        .running(running), .halted(halted), .seq_err(seq_err)
    );
    task automatic chk(input string name, input int got, input int exp);
        total_n++;
        if (got == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d", name, got, exp);
    endtask
    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask
    task automatic run_to(input int t);
        while (off != t) begin
            tick;
            off = (off + 1) % 168;
            if (!running) stalls++;
        end
    endtask
    initial begin
        tbl = '{
            '{0,   0, 1,  1, 1, 0, 0}, '{3,   3, 1,  1, 0, 0, 1},
            '{4,   0, 2,  1, 0, 0, 0}, '{55,  3, 14, 1, 0, 0, 1},
            '{56,  0, 1,  2, 0, 0, 0}, '{112, 0, 1,  3, 0, 0, 0},
            '{166, 2, 14, 3, 0, 0, 0}, '{167, 3, 14, 3, 0, 1, 1},
            '{168, 0, 1,  1, 1, 0, 0}, '{229, 1, 2,  2, 0, 0, 0},
            '{334, 2, 14, 3, 0, 0, 0}, '{335, 3, 14, 3, 0, 1, 1}
        };
        tick;
        chk("rst_sub", sub_strobe, 1);
        chk("rst_bt", bit_time, 1);
        chk("rst_pt", phase_time, 1);
        chk("rst_run", {running, halted, seq_err}, 3'b100);
        rst = 0;
        for (int n = 0, k = 0; n < 336; n++) begin
            if (k < 12 && tbl[k].n == n) begin
                chk($sformatf("t%0d_sub", n), sub_strobe, 1 << tbl[k].sub);
                chk($sformatf("t%0d_bt", n), bit_time, tbl[k].bt);
                chk($sformatf("t%0d_pt", n), phase_time, tbl[k].pt);
                chk($sformatf("t%0d_strb", n), {cycle_start, cycle_end, bt_end},
                    {tbl[k].cs, tbl[k].ce, tbl[k].be});
                k++;
            end
            if (bt_end != (n % 4 == 3) || bit_time != (n / 4) % 14 + 1 || phase_time != (n / 56) % 3 + 1
                || cycle_start != (n % 168 == 0) || cycle_end != (n % 168 == 167)) bad_n++;
            tick;
        end
        chk("free_run_model", bad_n, 0);
        off = 0;
        stalls = 0;
        run_to(72);
        chk("halt_at_pt2bt5", bit_time * 4 + phase_time, 5 * 4 + 2);
        halt_req = 1;
        run_to(167);
        chk("halt_pend_counts", stalls, 0);
        chk("halt_pend_ce", cycle_end, 1);
        tick;
        chk("halted", {halted, running, cycle_start, bt_end}, 4'b1000);
        chk("halted_sub", sub_strobe, 0);
        repeat (3) tick;
        chk("halted_frozen", {bit_time, phase_time, halted}, {4'd1, 2'd1, 1'b1});
        halt_req = 0;
        tick;
        chk("resume_cs", {cycle_start, running, halted}, 3'b110);
        chk("resume_sub", sub_strobe, 1);
        off = 0;
        stalls = 0;
        run_to(8);
        halt_req = 1;
        run_to(148);
        chk("cancel_at_pt3bt10", bit_time * 4 + phase_time, 10 * 4 + 3);
        halt_req = 0;
        run_to(20);
        chk("cancel_never_halts", stalls, 0);
        run_to(167);
        halt_req = 1;
        tick;
        chk("halt_on_ce", {halted, running}, 2'b10);
        halt_req = 0;
        tick;
        chk("halt_on_ce_resume", {cycle_start, running}, 2'b11);
        off = 0;
        run_to(10);
        chk("pre_err", seq_err, 0);
        force dut.pt = '0;
        tick;
        chk("err_set", seq_err, 1);
        chk("err_resync", {sub_strobe, bit_time}, {4'b0001, 4'd1});
        release dut.pt;
        repeat (5) tick;
        chk("err_sticky", seq_err, 1);
        rst = 1;
        #1;
        chk("async_rst", {seq_err, running, halted, sub_strobe, bit_time, phase_time},
            {3'b010, 4'b0001, 4'd1, 2'd1});
        @(negedge clk);
        rst = 0;
        off = 0;
`ifdef LVDC_SINGLE_STEP_EN
        halt_req = 1;
        run_to(167);
        tick;
        chk("step_pre_halted", halted, 1);
        step_req = 1;
        tick;
        step_req = 0;
        chk("step_start", {cycle_start, running}, 2'b11);
        cnt = 1;
        for (int i = 0; i < 400 && running; i++) begin
            step_req = (i == 50);
            tick;
            if (running) cnt++;
        end
        step_req = 0;
        chk("step_len", cnt, 168);
        chk("step_halted", halted, 1);
        step_req = 1;
        repeat (20) tick;
        step_req = 0;
        rst = 1;
        #1;
        chk("step_rst", {running, halted, sub_strobe}, {2'b10, 4'b0001});
        @(negedge clk);
        rst = 0;
        halt_req = 0;
`endif
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
